tag_retire_sched: RTL and testbench
===================================

# tag_retire_sched

Retire scheduler for the rename tag datapath. It collects retire requests from several writeback sources, buffers them per source, and round-robin arbitrates them onto the single retire port. One request per cycle goes out as a registered Enable/Discard/Tag/Addr bundle with a Trigger strobe. The block sits between the writeback units and the tag retire stage; that stage turns each triggered request into a commit-table write and/or a tag-pool release.

## Interface
- tag_w, 6, tag width.
- embedded, 1, selects the architectural register address width `addr_w` (4 when 1, 5 when 0). `addr_w` is derived locally and is not overridable.
- n_req, 2, number of requesters (2..4).
- depth, 2, per-requester FIFO depth (power of two, ≥2).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  n_req  request valid, one bit per requester.
- req_ready  out  n_req  request accepted when valid&ready at the clock edge.
- req_discard  in  n_req  1 = release tag only (no commit write).
- req_tag  in  n_req*tag_w  tag. Requester i occupies bits [i*tag_w +: tag_w].
- req_addr  in  n_req*addr_w  architectural destination, packed the same way as req_tag.
- ret_enable  out  1  output register valid.
- ret_discard  out  1  discard flag of the held request.
- ret_tag  out  tag_w  tag of the held request.
- ret_addr  out  addr_w  address of the held request.
- ret_ready  in  1  downstream can take the held request this cycle.
- ret_trigger  out  1  ret_enable & ret_ready & ~flush. This is the handshake strobe consumed by retire.
- flush  in  1  synchronous pipeline flush.
- busy  out  1  any FIFO non-empty or ret_enable high.

## Operation
- Each requester has its own `depth`-entry FIFO holding {discard, tag, addr}, with a registered count.
- req_ready[i] = (count_i < depth) & ~flush. It is derived from registered state only, with no combinational path from ret_ready or req_valid.
- Output register load condition: (~ret_enable | ret_trigger) & ~flush & any FIFO non-empty.
- Arbitration is round-robin over non-empty FIFOs:
  - The search starts at last_grant+1 and wraps modulo n_req.
  - last_grant updates only on a load.
  - The grant pops the head of the chosen FIFO in the same cycle.
- Order within one requester is preserved. Across requesters, order is arbitration order only; upstream guarantees no cross-source same-addr commit hazard.
- Output hold: while ret_enable & ~ret_ready, all ret_* fields stay stable and no FIFO pops.
- Push and pop on the same FIFO in the same cycle:
  - The count is unchanged.
  - When the FIFO is non-full this is legal.
  - When the FIFO is full, push cannot occur because ready is low.
- Flush has priority over everything. Next cycle:
  - all counts are 0,
  - ret_enable is 0,
  - read and write pointers are 0,
  - last_grant is unchanged.
- During the flush cycle, ret_trigger=0 and no push is accepted.
- Reset values:
  - All FIFOs are empty.
  - ret_enable, ret_discard, ret_tag, ret_addr, ret_trigger, busy are all 0.
  - last_grant = n_req-1, so requester 0 wins first.
  - req_ready is 0 while rst is low and all-ones on the first cycle after release.
- An asynchronous reset mid-operation discards all queued and held requests, with no partial trigger.

## Timing
- Latency: a request accepted at edge N is written to the FIFO at N. It can load the output register at N+1 and is visible on ret_enable in cycle N+1→N+2. ret_trigger asserts in that same cycle if ret_ready=1. Minimum accept-to-trigger is 2 cycles.
- Throughput is 1 retire per cycle sustained when ret_ready is held high (back-to-back triggers).
- ret_ready may toggle any cycle. The request is consumed only on a cycle where ret_trigger=1.
- With all requesters saturated and ret_ready=1, grants rotate 0,1,…,n_req-1,0… with no requester starved for more than n_req-1 loads.
- Pointer arithmetic is log2(depth) bits and wraps naturally. Count is log2(depth)+1 bits.

## Test plan
- Reset/single request:
  - Stimulus: hold rst low, check all outputs 0. Release rst, then push req0 {discard=0, tag=0x15, addr=3}.
  - Required response: 2 cycles later ret_enable=1, ret_tag=0x15, ret_addr=3, ret_trigger=1 for exactly 1 cycle.
- Round-robin:
  - Stimulus: with n_req=2, both requesters continuously valid with tags 0x10.. and 0x20.., ret_ready=1.
  - Required response: output order 0x10, 0x20, 0x11, 0x21, …; one trigger per cycle.
- Backpressure/full:
  - Stimulus: ret_ready=0, req0 pushes 3 tags.
  - Required response: the first is held on the outputs and stable; the FIFO fills to 2 and req_ready[0]=0. Raise ret_ready: all 3 tags retire in order on consecutive cycles, and ready returns.
- Discard passthrough:
  - Stimulus: req1 {discard=1, tag=0x3F, addr=7}.
  - Required response: ret_discard=1, ret_tag=0x3F, ret_trigger once.
- Flush:
  - Stimulus: both FIFOs partially full, output held (ret_ready=0), assert flush with ret_ready=1 in the same cycle.
  - Required response: ret_trigger=0 that cycle; next cycle busy=0, req_ready all-ones, and no stale entry ever appears.
- Async reset mid-burst:
  - Stimulus: drop rst while ret_enable=1.
  - Required response: ret_enable falls immediately without a clock edge, and after release the queue is empty.

Source files
------------

// File: rtl/tag_retire_sched.sv
// Retire scheduler: per-source request FIFOs feeding one registered retire port
// through a round-robin arbiter. The held request is consumed on ret_trigger.
module tag_retire_sched #(
    parameter int tag_w    = 6,
    parameter int embedded = 1,
    parameter int n_req    = 2,
    parameter int depth    = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [n_req-1:0]                    req_valid,
    output logic [n_req-1:0]                    req_ready,
    input  logic [n_req-1:0]                    req_discard,
    input  logic [n_req*tag_w-1:0]              req_tag,
    input  logic [n_req*(embedded != 0 ? 4 : 5)-1:0] req_addr,
    output logic                                ret_enable,
    output logic                                ret_discard,
    output logic [tag_w-1:0]                    ret_tag,
    output logic [(embedded != 0 ? 4 : 5)-1:0]  ret_addr,
    input  logic                                ret_ready,
    output logic                                ret_trigger,
    input  logic                                flush,
    output logic                                busy
);

    localparam int addr_w = (embedded != 0) ? 4 : 5;
    localparam int ptr_w  = $clog2(depth);
    localparam int cnt_w  = ptr_w + 1;
    localparam int gnt_w  = (n_req > 1) ? $clog2(n_req) : 1;
    localparam int ent_w  = 1 + tag_w + addr_w;

    logic [ent_w-1:0] mem    [n_req][depth];
    logic [ptr_w-1:0] wr_ptr [n_req];
    logic [ptr_w-1:0] rd_ptr [n_req];
    logic [cnt_w-1:0] count  [n_req];

    logic [n_req-1:0] nonempty;
    logic [n_req-1:0] push;
    logic [n_req-1:0] pop;
    logic [gnt_w-1:0] last_grant;
    logic [gnt_w-1:0] gnt;
    logic             found;
    logic             load;
    logic [ent_w-1:0] head_p0;

    assign ret_trigger = ret_enable & ret_ready & ~flush;
    assign busy        = (|nonempty) | ret_enable;

    // Per-source occupancy, ready and accepted push; ready depends only on registered counts.
    always_comb begin
        nonempty  = '0;
        req_ready = '0;
        push      = '0;
        for (int i = 0; i < n_req; i++) begin
            nonempty[i]  = (count[i] != '0);
            req_ready[i] = rst & ~flush & (count[i] < cnt_w'(depth));
            push[i]      = req_valid[i] & req_ready[i];
        end
    end

    // Round-robin pick: first non-empty source after last_grant, wrapping to 0.
    always_comb begin
        gnt   = last_grant;
        found = 1'b0;
        for (int i = 0; i < n_req; i++) begin
            if (!found && nonempty[i] && (i > int'(last_grant))) begin
                gnt   = gnt_w'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < n_req; i++) begin
            if (!found && nonempty[i] && (i <= int'(last_grant))) begin
                gnt   = gnt_w'(i);
                found = 1'b1;
            end
        end
        load = (~ret_enable | ret_trigger) & ~flush & (|nonempty);
        pop  = '0;
        if (load) begin
            pop[gnt] = 1'b1;
        end
        head_p0 = mem[gnt][rd_ptr[gnt]];
    end

    // FIFO storage: payload only, written at the tail on an accepted push.
    always_ff @(posedge clk) begin
        for (int i = 0; i < n_req; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= {req_discard[i], req_tag[i*tag_w +: tag_w],
                                      req_addr[i*addr_w +: addr_w]};
            end
        end
    end

    // FIFO pointers and counts; flush empties every queue in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < n_req; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < n_req; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < n_req; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + ptr_w'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + ptr_w'(1);
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + cnt_w'(1);
                    2'b01:   count[i] <= count[i] - cnt_w'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // Output register: loads a granted head when empty or being consumed, else holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ret_enable  <= 1'b0;
            ret_discard <= 1'b0;
            ret_tag     <= '0;
            ret_addr    <= '0;
            last_grant  <= gnt_w'(n_req - 1);
        end else if (flush) begin
            ret_enable <= 1'b0;
        end else if (load) begin
            ret_enable                        <= 1'b1;
            {ret_discard, ret_tag, ret_addr}  <= head_p0;
            last_grant                        <= gnt;
        end else if (ret_trigger) begin
            ret_enable <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tag_retire_sched.sv
// Bench for tag_retire_sched: directed scenarios followed by random traffic,
// all checked every cycle against a queue-based reference model.
module tb_tag_retire_sched;

    localparam int NREQ  = 2;
    localparam int DEPTH = 2;
    localparam int TW    = 6;
    localparam int AW    = 4;

    typedef struct packed {
        logic          d;
        logic [TW-1:0] t;
        logic [AW-1:0] a;
    } ent_t;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      valid_i;
    logic [NREQ-1:0]      ready_o;
    logic [NREQ-1:0]      discard_i;
    logic [NREQ*TW-1:0]   tag_i;
    logic [NREQ*AW-1:0]   addr_i;
    logic                 ret_enable;
    logic                 ret_discard;
    logic [TW-1:0]        ret_tag;
    logic [AW-1:0]        ret_addr;
    logic                 rr_i;
    logic                 ret_trigger;
    logic                 flush_i;
    logic                 busy;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    ent_t mq [NREQ][$];
    logic m_en;
    ent_t m_out;
    int   m_lg;
    int   acc [NREQ];
    ent_t dut_log [$];

    tag_retire_sched #(.tag_w(TW), .embedded(1), .n_req(NREQ), .depth(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(valid_i), .req_ready(ready_o), .req_discard(discard_i),
        .req_tag(tag_i), .req_addr(addr_i),
        .ret_enable(ret_enable), .ret_discard(ret_discard), .ret_tag(ret_tag),
        .ret_addr(ret_addr), .ret_ready(rr_i), .ret_trigger(ret_trigger),
        .flush(flush_i), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) begin
            mq[i].delete();
            acc[i] = 0;
        end
        m_en  = 1'b0;
        m_out = '0;
        m_lg  = NREQ - 1;
    endtask

    task automatic idle_inputs();
        valid_i   = '0;
        discard_i = '0;
        tag_i     = '0;
        addr_i    = '0;
        rr_i      = 1'b0;
        flush_i   = 1'b0;
    endtask

    // One clock: check outputs against the model before the edge, then advance the model.
    task automatic step();
        logic [NREQ-1:0] exp_rdy;
        logic exp_trig;
        logic exp_busy;
        logic load;
        logic found;
        int   g;
        ent_t e;
        #1;
        exp_busy = m_en;
        for (int i = 0; i < NREQ; i++) begin
            exp_rdy[i] = !flush_i && (mq[i].size() < DEPTH);
            if (mq[i].size() > 0) exp_busy = 1'b1;
        end
        exp_trig = m_en && rr_i && !flush_i;
        chk("req_ready", 32'(ready_o), 32'(exp_rdy));
        chk("ret_enable", 32'(ret_enable), 32'(m_en));
        chk("ret_trigger", 32'(ret_trigger), 32'(exp_trig));
        chk("busy", 32'(busy), 32'(exp_busy));
        if (m_en) begin
            chk("ret_tag", 32'(ret_tag), 32'(m_out.t));
            chk("ret_addr", 32'(ret_addr), 32'(m_out.a));
            chk("ret_discard", 32'(ret_discard), 32'(m_out.d));
        end
        if (ret_trigger === 1'b1) begin
            e.d = ret_discard; e.t = ret_tag; e.a = ret_addr;
            dut_log.push_back(e);
        end
        @(posedge clk);
        if (flush_i) begin
            for (int i = 0; i < NREQ; i++) mq[i].delete();
            m_en = 1'b0;
        end else begin
            load = (!m_en || exp_trig) && (mq[0].size() > 0 || mq[1].size() > 0);
            if (load) begin
                found = 1'b0;
                for (int k = 1; k <= NREQ; k++) begin
                    g = (m_lg + k) % NREQ;
                    if (!found && mq[g].size() > 0) begin
                        m_out = mq[g].pop_front();
                        m_lg  = g;
                        found = 1'b1;
                    end
                end
                m_en = 1'b1;
            end else if (exp_trig) begin
                m_en = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (valid_i[i] && exp_rdy[i]) begin
                    e.d = discard_i[i];
                    e.t = tag_i[i*TW +: TW];
                    e.a = addr_i[i*AW +: AW];
                    mq[i].push_back(e);
                    acc[i]++;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [5:0] t0;
        logic [5:0] t1;
        logic [7:0] exp_rr [8];
        idle_inputs();
        model_reset();
        rst = 1'b0;

        // reset state
        #13;
        chk("rst_enable", 32'(ret_enable), 32'd0);
        chk("rst_trigger", 32'(ret_trigger), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_tag", 32'(ret_tag), 32'd0);
        chk("rst_addr", 32'(ret_addr), 32'd0);
        chk("rst_discard", 32'(ret_discard), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("ready_after_rst", 32'(ready_o), 32'h3);

        // single request from requester 0
        valid_i = 2'b01; tag_i = {6'h00, 6'h15}; addr_i = {4'h0, 4'h3}; rr_i = 1'b1;
        step();
        valid_i = '0;
        step();
        chk("single_enable", 32'(ret_enable), 32'd1);
        chk("single_tag", 32'(ret_tag), 32'h15);
        chk("single_addr", 32'(ret_addr), 32'h3);
        chk("single_trigger", 32'(ret_trigger), 32'd1);
        step();
        chk("single_trigger_once", 32'(ret_trigger), 32'd0);
        step();

        // round robin, both requesters saturated
        do_reset();
        dut_log.delete();
        valid_i = 2'b11; rr_i = 1'b1;
        for (int s = 0; s < 12; s++) begin
            t0 = 6'h10 + 6'(acc[0]);
            t1 = 6'h20 + 6'(acc[1]);
            tag_i = {t1, t0};
            step();
        end
        chk("rr_one_per_cycle", 32'(dut_log.size()), 32'd10);
        valid_i = '0;
        for (int s = 0; s < 6; s++) step();
        exp_rr = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
        for (int k = 0; k < 8; k++) begin
            if (k < dut_log.size()) chk("rr_order", 32'(dut_log[k].t), 32'(exp_rr[k]));
            else chk("rr_count", 32'(dut_log.size()), 32'd8);
        end

        // backpressure and full FIFO
        for (int i = 0; i < NREQ; i++) acc[i] = 0;
        rr_i = 1'b0;
        for (int s = 0; s < 6; s++) begin
            valid_i = (acc[0] < 3) ? 2'b01 : 2'b00;
            t0 = 6'h30 + 6'(acc[0]);
            tag_i = {6'h00, t0};
            step();
        end
        chk("bp_accepted", 32'(acc[0]), 32'd3);
        chk("bp_hold_enable", 32'(ret_enable), 32'd1);
        chk("bp_hold_tag", 32'(ret_tag), 32'h30);
        chk("bp_full_ready", 32'(ready_o[0]), 32'd0);
        dut_log.delete();
        rr_i = 1'b1;
        for (int s = 0; s < 3; s++) step();
        chk("bp_drain_count", 32'(dut_log.size()), 32'd3);
        for (int k = 0; k < 3 && k < dut_log.size(); k++)
            chk("bp_drain_order", 32'(dut_log[k].t), 32'h30 + 32'(k));
        chk("bp_ready_back", 32'(ready_o[0]), 32'd1);
        step();

        // discard passthrough on requester 1
        dut_log.delete();
        valid_i = 2'b10; discard_i = 2'b10; tag_i = {6'h3F, 6'h00}; addr_i = {4'h7, 4'h0};
        step();
        idle_inputs(); rr_i = 1'b1;
        for (int s = 0; s < 4; s++) step();
        chk("disc_count", 32'(dut_log.size()), 32'd1);
        if (dut_log.size() > 0) begin
            chk("disc_flag", 32'(dut_log[0].d), 32'd1);
            chk("disc_tag", 32'(dut_log[0].t), 32'h3F);
            chk("disc_addr", 32'(dut_log[0].a), 32'h7);
        end

        // flush with output held and both FIFOs partly full
        rr_i = 1'b0; valid_i = 2'b11; tag_i = {6'h02, 6'h01};
        for (int s = 0; s < 3; s++) step();
        chk("fl_held", 32'(ret_enable), 32'd1);
        flush_i = 1'b1; rr_i = 1'b1;
        #1;
        chk("fl_trigger", 32'(ret_trigger), 32'd0);
        chk("fl_ready", 32'(ready_o), 32'd0);
        step();
        dut_log.delete();
        flush_i = 1'b0; valid_i = '0;
        #1;
        chk("fl_busy", 32'(busy), 32'd0);
        chk("fl_ready_after", 32'(ready_o), 32'h3);
        for (int s = 0; s < 5; s++) step();
        chk("fl_no_stale", 32'(dut_log.size()), 32'd0);

        // asynchronous reset while a request is held
        valid_i = 2'b01; tag_i = {6'h00, 6'h2A}; rr_i = 1'b0;
        step();
        valid_i = '0;
        step();
        chk("ar_enable_before", 32'(ret_enable), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_enable_drop", 32'(ret_enable), 32'd0);
        chk("ar_trigger", 32'(ret_trigger), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        dut_log.delete();
        rr_i = 1'b1;
        for (int s = 0; s < 3; s++) step();
        chk("ar_empty", 32'(dut_log.size()), 32'd0);

        // random traffic against the model
        for (int s = 0; s < 300; s++) begin
            valid_i   = 2'($urandom);
            discard_i = 2'($urandom);
            tag_i     = 12'($urandom);
            addr_i    = 8'($urandom);
            rr_i      = 1'($urandom);
            flush_i   = ($urandom_range(0, 15) == 0);
            step();
        end
        idle_inputs(); rr_i = 1'b1;
        for (int s = 0; s < 8; s++) step();
        chk("final_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
